da_mac_accumulator: RTL and testbench

- Receiving end of the FIFO bit-slice interface. Each cycle it takes one 64-bit slice: bit k of that slice is the current bit of tap sample k, presented MSB-first over 16 slices per frame.
- Each slice selects a sum of stored signed coefficients. The block shift-accumulates these sums in two's complement (distributed arithmetic) and outputs one FIR result per frame.
- Sits between the FIFO system's eight 8-bit slice outputs and the downstream output register.

---
 rtl/da_mac_accumulator_pkg.sv | 27 ++
 rtl/da_mac_accumulator_if.sv | 25 ++
 rtl/da_mac_accumulator_group_sum.sv | 23 ++
 rtl/da_mac_accumulator.sv | 127 ++++++++++++
 tb/tb_da_mac_accumulator.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/da_mac_accumulator_pkg.sv
// Shared constants, state encoding and stage-1 payload for the distributed-arithmetic MAC.
package da_mac_accumulator_pkg;

    localparam int unsigned NTAP   = 64;
    localparam int unsigned SAMP_W = 16;
    localparam int unsigned COEF_W = 16;
    localparam int unsigned ACC_W  = 40;
    localparam int unsigned GRP_W  = 8;
    localparam int unsigned NGRP   = NTAP / GRP_W;
    localparam int unsigned SUM_W  = COEF_W + 3;
    localparam int unsigned ADDR_W = $clog2(NTAP);
    localparam int unsigned CNT_W  = $clog2(SAMP_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // One accepted slice after group reduction, tagged with its frame position.
    typedef struct packed {
        logic                         first;
        logic                         last;
        logic [NGRP-1:0][SUM_W-1:0]   sums;
    } s1_t;

endpackage

// File: rtl/da_mac_accumulator_if.sv
// Coefficient write port, bit-slice input and result output of the DA accumulator.
interface da_mac_accumulator_if;
    import da_mac_accumulator_pkg::*;

    logic              coef_we;
    logic [ADDR_W-1:0] coef_addr;
    logic [COEF_W-1:0] coef_wdata;
    logic              frame_start;
    logic              slice_valid;
    logic [NTAP-1:0]   a_slice;
    logic              busy;
    logic [ACC_W-1:0]  y;
    logic              y_valid;

    modport master (
        output coef_we, coef_addr, coef_wdata, frame_start, slice_valid, a_slice,
        input  busy, y, y_valid
    );

    modport slave (
        input  coef_we, coef_addr, coef_wdata, frame_start, slice_valid, a_slice,
        output busy, y, y_valid
    );

endinterface

// File: rtl/da_mac_accumulator_group_sum.sv
// Signed sum of the coefficients of one 8-tap group whose select bit is set.
module da_group_sum
    import da_mac_accumulator_pkg::*;
(
    input  logic [GRP_W-1:0][COEF_W-1:0] coef_i,
    input  logic [GRP_W-1:0]             sel_i,
    output logic [SUM_W-1:0]             sum_c_o
);

    logic signed [SUM_W-1:0] sum_c;

    always_comb begin
        sum_c = '0;
        for (int unsigned j = 0; j < GRP_W; j++) begin
            if (sel_i[j]) begin
                sum_c = sum_c + SUM_W'($signed(coef_i[j]));
            end
        end
    end

    assign sum_c_o = sum_c;

endmodule

// File: rtl/da_mac_accumulator.sv
// Distributed-arithmetic FIR accumulator: MSB-first bit slices in, one signed result per frame.
module da_mac_accumulator
    import da_mac_accumulator_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    da_mac_accumulator_if.slave bus
);

    logic [NTAP-1:0][COEF_W-1:0] coef_q;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    drain_q;
    logic                    busy_q;
    logic                    accept_c;

    logic [NGRP-1:0][SUM_W-1:0] gsum_c;
    s1_t                     s1_q;
    logic                    s1_valid_q;

    logic signed [ACC_W-1:0] p_c;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0]        y_q;
    logic                    y_valid_q;

    // frame_start wins over a slice presented in the same cycle.
    assign accept_c = (state_q == ST_RUN) && bus.slice_valid && !bus.frame_start;

    always_ff @(posedge clk) begin
        if (reset) begin
            coef_q <= '0;
        end else if (bus.coef_we) begin
            coef_q[bus.coef_addr] <= bus.coef_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            drain_q <= 1'b0;
            busy_q  <= 1'b0;
        end else if (bus.frame_start) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            drain_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (accept_c) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(SAMP_W - 1)) begin
                            state_q <= ST_DRAIN;
                            drain_q <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    drain_q <= 1'b1;
                    if (drain_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_IDLE: ;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        da_group_sum u_grp (
            .coef_i  (coef_q[g*GRP_W +: GRP_W]),
            .sel_i   (bus.a_slice[g*GRP_W +: GRP_W]),
            .sum_c_o (gsum_c[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else begin
            s1_valid_q <= accept_c;
            if (accept_c) begin
                s1_q.first <= (cnt_q == '0);
                s1_q.last  <= (cnt_q == CNT_W'(SAMP_W - 1));
                s1_q.sums  <= gsum_c;
            end
        end
    end

    // Sign slice carries weight -2^(SAMP_W-1), hence the negation on first.
    always_comb begin
        p_c = '0;
        for (int unsigned g = 0; g < NGRP; g++) begin
            p_c = p_c + ACC_W'($signed(s1_q.sums[g]));
        end
        acc_d = s1_q.first ? -p_c : ((acc_q <<< 1) + p_c);
    end

    // A frame_start in flight kills the pending stage-2 update of the aborted frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            y_valid_q <= 1'b0;
            if (s1_valid_q && !bus.frame_start) begin
                acc_q <= acc_d;
                if (s1_q.last) begin
                    y_q       <= acc_d;
                    y_valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.busy    = busy_q;
    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;

endmodule

// File: tb/tb_da_mac_accumulator.sv
// Randomized scoreboard bench for da_mac_accumulator against a dot-product reference model.
module tb_da_mac_accumulator;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    da_mac_accumulator_if bus ();

    da_mac_accumulator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [39:0] y;
        int          cyc;
    } exp_t;

    exp_t               sb_q[$];
    logic signed [15:0] model_coef [64];
    logic signed [15:0] samp [64];
    logic [39:0]        last_y;

    // Reference: y = sum_k coef[k] * sample[k], two's complement, modulo 2^40.
    function automatic logic [39:0] model_y();
        longint acc = 0;
        for (int k = 0; k < 64; k++) acc += longint'(model_coef[k]) * longint'(samp[k]);
        return 40'(acc);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.y_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_y_valid: y=%0d at cycle %0d, expected no pulse",
                         $signed(bus.y), cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("y_value", 64'(bus.y), 64'(e.y));
                chk("y_latency_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    task automatic set_coef(input int a, input logic [15:0] v);
        bus.slice_valid = 1'b0;
        bus.coef_we     = 1'b1;
        bus.coef_addr   = 6'(a);
        bus.coef_wdata  = v;
        @(posedge clk); #1;
        bus.coef_we     = 1'b0;
        model_coef[a]   = v;
    endtask

    task automatic fill_coef(input logic [15:0] v);
        for (int k = 0; k < 64; k++) set_coef(k, v);
    endtask

    task automatic fill_samp(input logic [15:0] v);
        for (int k = 0; k < 64; k++) samp[k] = v;
    endtask

    // Idle cycles with junk slice_valid: state must be IDLE or DRAIN here.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_start = 1'b0;
            bus.slice_valid = 1'($urandom_range(0, 1));
            bus.a_slice     = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        bus.slice_valid = 1'b0;
    endtask

    // Starts a frame and feeds n MSB-first slices; returns one cycle after the last slice.
    task automatic run_frame(input int n, input bit expect_out, input int gap_after,
                             input int gap_len, input bit wr15, input int wa,
                             input logic [15:0] wd);
        logic [39:0] e;
        logic [63:0] sl;
        e = model_y();
        bus.frame_start = 1'b1;
        bus.slice_valid = 1'($urandom_range(0, 1));
        bus.a_slice     = {$urandom, $urandom};
        @(posedge clk); #1;
        bus.frame_start = 1'b0;
        chk("busy_in_frame", 64'(bus.busy), 64'd1);
        for (int s = 0; s < n; s++) begin
            if (s == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    bus.slice_valid = 1'b0;
                    bus.a_slice     = {$urandom, $urandom};
                    @(posedge clk); #1;
                end
            end
            for (int k = 0; k < 64; k++) sl[k] = samp[k][15-s];
            bus.slice_valid = 1'b1;
            bus.a_slice     = sl;
            if (s == 15 && wr15) begin
                bus.coef_we    = 1'b1;
                bus.coef_addr  = 6'(wa);
                bus.coef_wdata = wd;
            end
            if (s == 15 && expect_out) begin
                sb_q.push_back('{e, cyc + 2});
                last_y = e;
            end
            @(posedge clk); #1;
            bus.slice_valid = 1'b0;
            bus.coef_we     = 1'b0;
            if (s == 15 && wr15) model_coef[wa] = wd;
        end
    endtask

    task automatic settle_and_check(input string name);
        idle(5);
        chk({name, "_busy_low"}, 64'(bus.busy), 64'd0);
        chk({name, "_y_held"}, 64'(bus.y), 64'(last_y));
    endtask

    initial begin
        reset           = 1'b1;
        bus.coef_we     = 1'b0;
        bus.coef_addr   = '0;
        bus.coef_wdata  = '0;
        bus.frame_start = 1'b0;
        bus.slice_valid = 1'b0;
        bus.a_slice     = '0;
        last_y          = '0;
        for (int k = 0; k < 64; k++) begin
            model_coef[k] = '0;
            samp[k]       = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_y", 64'(bus.y), 64'd0);
        chk("reset_y_valid", 64'(bus.y_valid), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);
        chk("post_reset_busy", 64'(bus.busy), 64'd0);

        // Slice 15 all-ones only: +64.
        fill_coef(16'd1);
        fill_samp(16'h0001);
        run_frame(16, 1, -1, 0, 0, 0, '0);
        settle_and_check("plus64");

        // All-ones samples are -1 each: -64.
        fill_samp(16'hFFFF);
        run_frame(16, 1, -1, 0, 0, 0, '0);
        settle_and_check("minus64");

        // Single tap with the most positive sample, then a negative coefficient.
        fill_coef(16'd0);
        set_coef(5, 16'd3);
        fill_samp(16'h0000);
        samp[5] = 16'h7FFF;
        run_frame(16, 1, -1, 0, 0, 0, '0);
        settle_and_check("single_tap_max");
        set_coef(5, -16'sd2);
        samp[5] = 16'd100;
        run_frame(16, 1, -1, 0, 0, 0, '0);
        settle_and_check("single_tap_neg");

        // Three stall cycles after slice 4.
        set_coef(5, 16'd0);
        set_coef(0, -16'sd2);
        fill_samp(16'h0000);
        samp[0] = 16'd100;
        run_frame(16, 1, 5, 3, 0, 0, '0);
        settle_and_check("gaps");

        // Abort in RUN after 7 slices, then a complete frame.
        fill_coef(16'd1);
        fill_samp(16'h0001);
        run_frame(7, 0, -1, 0, 0, 0, '0);
        run_frame(16, 1, -1, 0, 0, 0, '0);
        settle_and_check("abort_run");

        // Abort in DRAIN, while the last slice is still in the pipeline.
        fill_samp(16'h0003);
        run_frame(16, 0, -1, 0, 0, 0, '0);
        fill_samp(16'h0001);
        run_frame(16, 1, -1, 0, 0, 0, '0);
        settle_and_check("abort_drain");

        // Write coinciding with slice 15 affects only the following frame.
        run_frame(16, 1, -1, 0, 1, 0, 16'd5);
        settle_and_check("wr_old_coef");
        run_frame(16, 1, -1, 0, 0, 0, '0);
        settle_and_check("wr_new_coef");

        // Reset mid-frame: everything cleared, no result.
        run_frame(7, 0, -1, 0, 0, 0, '0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 64; k++) model_coef[k] = '0;
        last_y = '0;
        @(negedge clk);
        chk("midreset_busy", 64'(bus.busy), 64'd0);
        chk("midreset_y", 64'(bus.y), 64'd0);
        chk("midreset_y_valid", 64'(bus.y_valid), 64'd0);
        @(posedge clk); #1;
        settle_and_check("midreset");

        // Random coefficients, samples and stalls.
        for (int f = 0; f < 24; f++) begin
            int nw;
            nw = $urandom_range(4, 16);
            for (int w = 0; w < nw; w++) set_coef($urandom_range(0, 63), 16'($urandom));
            for (int k = 0; k < 64; k++) samp[k] = 16'($urandom);
            if (f % 4 == 0) for (int k = 0; k < 64; k++) samp[k] = 16'h8000;
            run_frame(16, 1, $urandom_range(0, 20), $urandom_range(0, 4), 0, 0, '0);
            idle($urandom_range(1, 4));
        end
        settle_and_check("random_end");

        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
